// File: rtl/wb_mem_pkg.sv
// wb_mem_pkg: shared types and limits for the Wishbone memory responder.
package wb_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_TURN
  } state_e;

  localparam int unsigned WORD_BYTES      = 4;
  localparam int unsigned WAIT_STATES_MAX = 15;
  localparam int unsigned TURNAROUND_MAX  = 3;

  function automatic logic is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/wb_mem_bram.sv
// wb_mem_bram: synchronous single-port RAM, per-byte write enables.
//   clk_i   clock            en_i    access enable      we_i   1 = write, 0 = read
//   be_i    byte enables     addr_i  word index         wdata_i / rdata_o  data
// rdata_o only changes on a read access, so it holds the last read word.
module wb_mem_bram
  import wb_mem_pkg::*;
#(
  parameter int unsigned WORDS       = 1024,
  parameter              MEMORY_FILE = "",
  localparam int unsigned AW         = $clog2(WORDS)
) (
  input  logic                    clk_i,
  input  logic                    en_i,
  input  logic                    we_i,
  input  logic [WORD_BYTES-1:0]   be_i,
  input  logic [AW-1:0]           addr_i,
  input  logic [8*WORD_BYTES-1:0] wdata_i,
  output logic [8*WORD_BYTES-1:0] rdata_o
);

  logic [8*WORD_BYTES-1:0] mem [WORDS];
  logic [8*WORD_BYTES-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int unsigned b = 0; b < WORD_BYTES; b++) begin
          if (be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        rdata_q <= mem[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_mem_responder.sv
// wb_mem_responder: Wishbone slave in front of a word-addressed RAM, with
// programmable wait states and a post-response turnaround window.
//   sys_clk, rst_n (async, active-low)
//   wb_cyc_i/wb_stb_i/wb_we_i/wb_sel_i/wb_addr_i/wb_data_i  request
//   wb_data_o/wb_ack_o/wb_err_o                              response
module wb_mem_responder
  import wb_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned TURNAROUND  = 1,
  parameter              MEMORY_FILE = ""
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_addr_i,
  input  logic [31:0] wb_data_i,
  output logic [31:0] wb_data_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  if (!is_pow2(MEM_WORDS) || MEM_WORDS < 2 || MEM_WORDS > (1 << 30)) begin : g_bad_words
    $error("wb_mem_responder: MEM_WORDS must be a power of two in 2..2^30");
  end
  if (WAIT_STATES > WAIT_STATES_MAX) begin : g_bad_wait
    $error("wb_mem_responder: WAIT_STATES out of range");
  end
  if (TURNAROUND > TURNAROUND_MAX) begin : g_bad_turn
    $error("wb_mem_responder: TURNAROUND out of range");
  end

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [29:0] waddr_q;
  logic [31:0] wdata_q;
  logic        ack_q;
  logic        err_q;
  logic        data_zero_q;

  logic        req;
  logic        fire;
  logic        in_range;
  logic        op_we;
  logic [3:0]  op_sel;
  logic [29:0] op_waddr;
  logic [31:0] op_wdata;
  logic [31:0] ram_rdata;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^wb_addr_i[1:0];

  // The RAM access happens on the edge entering RESP. With zero wait states
  // that edge is the request edge itself, so the bus inputs feed the RAM
  // directly instead of the captured copies.
  always_comb begin
    req      = wb_cyc_i & wb_stb_i;
    op_we    = we_q;
    op_sel   = sel_q;
    op_waddr = waddr_q;
    op_wdata = wdata_q;
    fire     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        op_we    = wb_we_i;
        op_sel   = wb_sel_i;
        op_waddr = wb_addr_i[31:2];
        op_wdata = wb_data_i;
        fire     = req && (WAIT_STATES == 0);
      end
      ST_WAIT: fire = wb_cyc_i && (cnt_q == '0);
      default: fire = 1'b0;
    endcase
    in_range = (op_waddr >> AW) == '0;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      data_zero_q <= 1'b1;
    end else begin
      ack_q <= fire & in_range;
      err_q <= fire & ~in_range;
      if (fire) begin
        if (!in_range)  data_zero_q <= 1'b1;
        else if (!op_we) data_zero_q <= 1'b0;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (req) begin
            we_q    <= wb_we_i;
            sel_q   <= wb_sel_i;
            waddr_q <= wb_addr_i[31:2];
            wdata_q <= wb_data_i;
            if (WAIT_STATES == 0) begin
              state_q <= ST_RESP;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= 4'(WAIT_STATES - 1);
            end
          end
        end
        ST_WAIT: begin
          if (!wb_cyc_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == '0) begin
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (TURNAROUND == 0) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_TURN;
            cnt_q   <= 4'(TURNAROUND - 1);
          end
        end
        ST_TURN: begin
          if (cnt_q == '0) state_q <= ST_IDLE;
          else             cnt_q   <= cnt_q - 4'd1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  wb_mem_bram #(
    .WORDS       (MEM_WORDS),
    .MEMORY_FILE (MEMORY_FILE)
  ) u_bram (
    .clk_i   (sys_clk),
    .en_i    (fire & in_range),
    .we_i    (op_we),
    .be_i    (op_sel),
    .addr_i  (op_waddr[AW-1:0]),
    .wdata_i (op_wdata),
    .rdata_o (ram_rdata)
  );

  assign wb_ack_o  = ack_q;
  assign wb_err_o  = err_q;
  assign wb_data_o = data_zero_q ? '0 : ram_rdata;

endmodule

// File: tb/tb_wb_mem_responder.sv
module tb_wb_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        cyc  [3];
  logic        stb  [3];
  logic        we   [3];
  logic [3:0]  sel  [3];
  logic [31:0] addr [3];
  logic [31:0] wdat [3];
  logic [31:0] rdat [3];
  logic        ack  [3];
  logic        err  [3];

  int checks;
  int failures;

  // dut0: WS=1 TA=1, dut1: WS=3 TA=1, dut2: WS=0 TA=0
  wb_mem_responder #(.MEM_WORDS(1024), .WAIT_STATES(1), .TURNAROUND(1), .MEMORY_FILE("")) u_dut0 (
    .sys_clk(clk), .rst_n(rst_n), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
    .wb_sel_i(sel[0]), .wb_addr_i(addr[0]), .wb_data_i(wdat[0]),
    .wb_data_o(rdat[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0]));

  wb_mem_responder #(.MEM_WORDS(1024), .WAIT_STATES(3), .TURNAROUND(1), .MEMORY_FILE("")) u_dut1 (
    .sys_clk(clk), .rst_n(rst_n), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
    .wb_sel_i(sel[1]), .wb_addr_i(addr[1]), .wb_data_i(wdat[1]),
    .wb_data_o(rdat[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1]));

  wb_mem_responder #(.MEM_WORDS(1024), .WAIT_STATES(0), .TURNAROUND(0), .MEMORY_FILE("")) u_dut2 (
    .sys_clk(clk), .rst_n(rst_n), .wb_cyc_i(cyc[2]), .wb_stb_i(stb[2]), .wb_we_i(we[2]),
    .wb_sel_i(sel[2]), .wb_addr_i(addr[2]), .wb_data_i(wdat[2]),
    .wb_data_o(rdat[2]), .wb_ack_o(ack[2]), .wb_err_o(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference memory for dut0: 1024 words, byte address space 0..0xFFF.
  logic [31:0] mdl [1024];

  function automatic void model_apply(input logic w, input logic [3:0] s, input logic [31:0] a,
                                      input logic [31:0] d, output logic e, output logic [31:0] rd);
    int unsigned idx;
    if (a >= 32'd4096) begin
      e  = 1'b1;
      rd = 32'h0;
      return;
    end
    e   = 1'b0;
    idx = a / 4;
    rd  = mdl[idx];
    if (w) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic start_req(input int d, input logic w, input logic [3:0] s,
                           input logic [31:0] a, input logic [31:0] dd);
    @(posedge clk); #1;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; sel[d] = s; addr[d] = a; wdat[d] = dd;
    @(posedge clk); #1;
    stb[d] = 1'b0;
  endtask

  task automatic wait_resp(input int d, output int lat, output logic a_o,
                           output logic e_o, output logic [31:0] rd);
    lat = 0; a_o = 1'b0; e_o = 1'b0; rd = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ack[d] || err[d]) begin
        lat = k; a_o = ack[d]; e_o = err[d]; rd = rdat[d];
        break;
      end
    end
    if (lat == 0) begin
      checks++;
      failures++;
      $display("FAIL timeout dut%0d: no ack/err within 20 cycles", d);
    end else begin
      check("ack_err_exclusive", 32'(a_o & e_o), 32'h0);
      @(negedge clk);
      check("one_cycle_pulse", {30'b0, ack[d], err[d]}, 32'h0);
    end
    cyc[d] = 1'b0;
  endtask

  task automatic txn(input int d, input logic w, input logic [3:0] s, input logic [31:0] a,
                     input logic [31:0] dd, output int lat, output logic a_o,
                     output logic e_o, output logic [31:0] rd);
    start_req(d, w, s, a, dd);
    wait_resp(d, lat, a_o, e_o, rd);
  endtask

  typedef struct {
    logic        w;
    logic [3:0]  s;
    logic [31:0] a;
    logic [31:0] d;
    logic        exp_err;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vt [16];

  initial begin
    int          lat;
    logic        ga, ge, ee;
    logic [31:0] gd, ed, wv, av;
    logic        wr;
    logic [3:0]  sv;
    logic        seen;

    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; sel[d] = '0; addr[d] = '0; wdat[d] = '0;
    end

    vt[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
    vt[2]  = '{1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344, 1'b0, 1'b0, 32'h0};
    vt[3]  = '{1'b1, 4'h5, 32'h0000_0020, 32'hAABB_CCDD, 1'b0, 1'b0, 32'h0};
    vt[4]  = '{1'b0, 4'h0, 32'h0000_0020, 32'h0,         1'b0, 1'b1, 32'h11BB_33DD};
    vt[5]  = '{1'b1, 4'hF, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0};
    vt[6]  = '{1'b0, 4'hF, 32'h0000_1000, 32'h0,         1'b1, 1'b1, 32'h0};
    vt[7]  = '{1'b1, 4'hF, 32'h0000_1000, 32'h1234_5678, 1'b1, 1'b1, 32'h0};
    vt[8]  = '{1'b0, 4'hF, 32'h0000_0000, 32'h0,         1'b0, 1'b1, 32'hCAFE_F00D};
    vt[9]  = '{1'b1, 4'hF, 32'h0000_0024, 32'h0102_0304, 1'b0, 1'b0, 32'h0};
    vt[10] = '{1'b1, 4'h0, 32'h0000_0024, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0};
    vt[11] = '{1'b0, 4'hF, 32'h0000_0024, 32'h0,         1'b0, 1'b1, 32'h0102_0304};
    vt[12] = '{1'b0, 4'h3, 32'h0000_0013, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
    vt[13] = '{1'b0, 4'hF, 32'h8000_0010, 32'h0,         1'b1, 1'b1, 32'h0};
    vt[14] = '{1'b1, 4'hF, 32'h0000_0FFC, 32'h5A5A_5A5A, 1'b0, 1'b0, 32'h0};
    vt[15] = '{1'b0, 4'hF, 32'h0000_0FFC, 32'h0,         1'b0, 1'b1, 32'h5A5A_5A5A};

    // Reset state
    #3;
    for (int d = 0; d < 3; d++) begin
      check("reset_ack", {31'b0, ack[d]}, 32'h0);
      check("reset_err", {31'b0, err[d]}, 32'h0);
      check("reset_data", rdat[d], 32'h0);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Directed table on dut0
    for (int i = 0; i < 16; i++) begin
      model_apply(vt[i].w, vt[i].s, vt[i].a, vt[i].d, ee, ed);
      txn(0, vt[i].w, vt[i].s, vt[i].a, vt[i].d, lat, ga, ge, gd);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      check($sformatf("vec%0d_ack", i), {31'b0, ga}, {31'b0, ~vt[i].exp_err});
      check($sformatf("vec%0d_err", i), {31'b0, ge}, {31'b0, vt[i].exp_err});
      if (vt[i].chk_data) check($sformatf("vec%0d_rdata", i), gd, vt[i].exp_data);
    end

    // Turnaround: strobe held through the cycle after ack with new data must be ignored
    @(posedge clk); #1;
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'hF; addr[0] = 32'h30; wdat[0] = 32'hA5A5_0001;
    model_apply(1'b1, 4'hF, 32'h30, 32'hA5A5_0001, ee, ed);
    @(posedge clk);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ack[0]) begin lat = k; break; end
    end
    check("turn_latency", 32'(lat), 32'd2);
    wdat[0] = 32'h0BAD_0002;
    @(posedge clk);
    @(negedge clk);
    check("turn_no_second_ack", {30'b0, ack[0], err[0]}, 32'h0);
    @(posedge clk); #1;
    stb[0] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seen = seen | ack[0] | err[0];
    end
    check("turn_quiet_after", {31'b0, seen}, 32'h0);
    cyc[0] = 1'b0;
    txn(0, 1'b0, 4'hF, 32'h30, 32'h0, lat, ga, ge, gd);
    check("turn_readback", gd, 32'hA5A5_0001);

    // Randomised traffic on dut0 against the reference memory
    for (int i = 0; i < 32; i++) begin
      wv = $urandom;
      model_apply(1'b1, 4'hF, 32'(i * 4), wv, ee, ed);
      txn(0, 1'b1, 4'hF, 32'(i * 4), wv, lat, ga, ge, gd);
      check("fill_ack", {31'b0, ga}, 32'h1);
    end
    for (int i = 0; i < 250; i++) begin
      wr = 1'($urandom_range(0, 1));
      sv = 4'($urandom);
      if ($urandom_range(0, 7) == 0) av = $urandom | 32'h0000_1000;
      else av = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
      wv = $urandom;
      model_apply(wr, sv, av, wv, ee, ed);
      txn(0, wr, sv, av, wv, lat, ga, ge, gd);
      check("rand_latency", 32'(lat), 32'd2);
      check("rand_err", {31'b0, ge}, {31'b0, ee});
      check("rand_ack", {31'b0, ga}, {31'b0, ~ee});
      if (!wr || ee) check("rand_rdata", gd, ed);
    end

    // Abort on dut1 (WS=3): cyc dropped in WAIT, and low on the edge entering RESP
    txn(1, 1'b1, 4'hF, 32'h40, 32'h0BAD_F00D, lat, ga, ge, gd);
    check("ws3_latency", 32'(lat), 32'd4);
    check("ws3_ack", {31'b0, ga}, 32'h1);
    for (int drop = 1; drop <= 3; drop += 2) begin
      start_req(1, 1'b1, 4'hF, 32'h40, 32'hFFFF_0000 + 32'(drop));
      repeat (drop - 1) @(posedge clk);
      #1;
      cyc[1] = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        seen = seen | ack[1] | err[1];
      end
      check($sformatf("abort%0d_no_response", drop), {31'b0, seen}, 32'h0);
    end
    txn(1, 1'b0, 4'hF, 32'h40, 32'h0, lat, ga, ge, gd);
    check("abort_mem_unchanged", gd, 32'h0BAD_F00D);
    check("ws3_read_latency", 32'(lat), 32'd4);

    // Zero wait on dut2: back-to-back reads, one served per two cycles
    txn(2, 1'b1, 4'hF, 32'h0, 32'h1357_9BDF, lat, ga, ge, gd);
    check("ws0_latency", 32'(lat), 32'd1);
    txn(2, 1'b1, 4'hF, 32'h4, 32'h2468_ACE0, lat, ga, ge, gd);
    check("ws0_latency2", 32'(lat), 32'd1);
    @(posedge clk); #1;
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; sel[2] = 4'hF; addr[2] = 32'h0;
    @(posedge clk); #1;
    addr[2] = 32'h4;
    @(negedge clk);
    check("b2b_ack0", {31'b0, ack[2]}, 32'h1);
    check("b2b_data0", rdat[2], 32'h1357_9BDF);
    @(negedge clk);
    check("b2b_gap", {30'b0, ack[2], err[2]}, 32'h0);
    @(negedge clk);
    check("b2b_ack1", {31'b0, ack[2]}, 32'h1);
    check("b2b_data1", rdat[2], 32'h2468_ACE0);
    stb[2] = 1'b0; cyc[2] = 1'b0;
    @(negedge clk);
    check("b2b_end", {30'b0, ack[2], err[2]}, 32'h0);

    // Reset during WAIT on dut0
    txn(0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, lat, ga, ge, gd);
    txn(0, 1'b0, 4'hF, 32'h10, 32'h0, lat, ga, ge, gd);
    check("pre_reset_read", gd, 32'hDEAD_BEEF);
    start_req(0, 1'b1, 4'hF, 32'h10, 32'h5555_5555);
    check("data_held_after_read", rdat[0], 32'hDEAD_BEEF);
    rst_n = 1'b0;
    #1;
    check("async_reset_ack", {31'b0, ack[0]}, 32'h0);
    check("async_reset_err", {31'b0, err[0]}, 32'h0);
    check("async_reset_data", rdat[0], 32'h0);
    @(posedge clk); @(posedge clk); #1;
    cyc[0] = 1'b0;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      seen = seen | ack[0] | err[0];
    end
    check("reset_no_response", {31'b0, seen}, 32'h0);
    txn(0, 1'b0, 4'hF, 32'h10, 32'h0, lat, ga, ge, gd);
    check("reset_mem_retained", gd, 32'hDEAD_BEEF);
    check("reset_read_ack", {31'b0, ga}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
